// File: rtl/nd_2to1_arbiter.sv
// Round-robin merge of two 4-phase req/ack message channels onto one, holding one message
// and optionally checking its redundancy field at capture; all handshake inputs are 2-flop synchronized.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1_arbiter #(
  parameter int ASZ       = `NS_ADDRESS_SIZE,
  parameter int DSZ       = `NS_DATA_SIZE,
  parameter int RSZ       = `NS_REDUN_SIZE,
  parameter bit CHECK_RED = 1'b1,
  parameter bit DROP_BAD  = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req_in,
  output logic           i0_ack_out,
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [RSZ-1:0] i1_red,
  input  logic           i1_req_in,
  output logic           i1_ack_out,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req_out,
  input  logic           o0_ack_in,
  output logic           err_flag,
  output logic [7:0]     err_cnt,
  output logic           last_gnt
);

  localparam int MW = 2*ASZ + DSZ;

  typedef enum logic [1:0] {IDLE, IN_ACK, SEND, OUT_REL} state_t;

  state_t         state;
  logic [1:0]     i0_sync, i1_sync, ack_sync;
  logic           s_i0_req, s_i1_req, s_o0_ack;
  logic           gnt, bad;
  logic           pick, sel_bad;
  logic [ASZ-1:0] sel_src, sel_dst;
  logic [DSZ-1:0] sel_dat;
  logic [RSZ-1:0] sel_red;

  // Redundancy is the XOR of all RSZ-wide chunks of {src,dst,dat}.
  function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] src,
                                                input logic [ASZ-1:0] dst,
                                                input logic [DSZ-1:0] dat);
    logic [MW-1:0]  v;
    logic [RSZ-1:0] r;
    v = {src, dst, dat};
    r = '0;
    for (int c = 0; c < MW; c += RSZ) r = r ^ RSZ'(v >> c);
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i0_sync  <= '0;
      i1_sync  <= '0;
      ack_sync <= '0;
    end else begin
      i0_sync  <= {i0_sync[0], i0_req_in};
      i1_sync  <= {i1_sync[0], i1_req_in};
      ack_sync <= {ack_sync[0], o0_ack_in};
    end
  end

  assign s_i0_req = i0_sync[1];
  assign s_i1_req = i1_sync[1];
  assign s_o0_ack = ack_sync[1];

  always_comb begin
    pick    = (s_i0_req && s_i1_req) ? ~last_gnt : s_i1_req;
    sel_src = pick ? i1_src : i0_src;
    sel_dst = pick ? i1_dst : i0_dst;
    sel_dat = pick ? i1_dat : i0_dat;
    sel_red = pick ? i1_red : i0_red;
    sel_bad = CHECK_RED && (sel_red != calc_redun(sel_src, sel_dst, sel_dat));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      i0_ack_out <= 1'b0;
      i1_ack_out <= 1'b0;
      o0_req_out <= 1'b0;
      o0_src     <= '0;
      o0_dst     <= '0;
      o0_dat     <= '0;
      o0_red     <= '0;
      err_flag   <= 1'b0;
      err_cnt    <= '0;
      last_gnt   <= 1'b1;
      gnt        <= 1'b0;
      bad        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A lingering downstream ack blocks new grants until it is released.
          if ((s_i0_req || s_i1_req) && !s_o0_ack) begin
            gnt        <= pick;
            last_gnt   <= pick;
            o0_src     <= sel_src;
            o0_dst     <= sel_dst;
            o0_dat     <= sel_dat;
            o0_red     <= sel_red;
            bad        <= sel_bad;
            i0_ack_out <= ~pick;
            i1_ack_out <= pick;
            if (sel_bad) begin
              err_flag <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            state <= IN_ACK;
          end
        end
        IN_ACK: begin
          if (!(gnt ? s_i1_req : s_i0_req)) begin
            i0_ack_out <= 1'b0;
            i1_ack_out <= 1'b0;
            if (bad && DROP_BAD) begin
              state <= IDLE;
            end else begin
              o0_req_out <= 1'b1;
              state      <= SEND;
            end
          end
        end
        SEND: begin
          if (s_o0_ack) begin
            o0_req_out <= 1'b0;
            state      <= OUT_REL;
          end
        end
        OUT_REL: begin
          if (!s_o0_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
